// File: rtl/rv_pkg.sv
// Shared constants and types for the UART debug/loader bridge.
package rv_pkg;

  localparam int unsigned XLEN = 32;

  localparam logic [7:0] CMD_WRITE = 8'h57;
  localparam logic [7:0] CMD_READ  = 8'h52;
  localparam logic [7:0] RSP_ACK   = 8'h4B;
  localparam logic [7:0] RSP_ERR   = 8'h45;
  localparam logic [7:0] RSP_TMO   = 8'h54;

  typedef enum logic [2:0] {
    S_IDLE,
    S_ADDR,
    S_DATA,
    S_BUS_REQ,
    S_BUS_WAIT,
    S_RESP
  } dbg_state_t;

endpackage

// File: rtl/rv_uart_phy.sv
// 8N1 UART byte engines: rx synchronizer + receiver, transmitter, baud counters.
module rv_uart_phy #(
  parameter int unsigned CLK_FREQ  = 25_000_000,
  parameter int unsigned BAUD_RATE = 9600
) (
  input  logic       clk_i,
  input  logic       arst_i,
  input  logic       uart_rx,
  output logic       uart_tx,
  output logic       rx_valid_o,
  output logic       rx_err_o,
  output logic [7:0] rx_data_o,
  input  logic       tx_start_i,
  input  logic [7:0] tx_data_i,
  output logic       tx_done_o
);

  localparam int unsigned ClksPerBit = CLK_FREQ / BAUD_RATE;
  localparam int unsigned CntW       = $clog2(ClksPerBit) + 1;
  localparam logic [CntW-1:0] BitLast  = CntW'(ClksPerBit - 1);
  localparam logic [CntW-1:0] HalfLast = CntW'(ClksPerBit / 2 - 1);

  typedef enum logic [1:0] {RxIdle, RxStart, RxData, RxStop} rx_state_e;

  rx_state_e       rx_state_q, rx_state_d;
  logic            rx_s1_q, rx_s2_q, rx_s3_q;
  logic [CntW-1:0] rx_cnt_q, rx_cnt_d;
  logic [2:0]      rx_bit_q, rx_bit_d;
  logic [7:0]      rx_sr_q, rx_sr_d;
  logic            rx_valid_q, rx_valid_d, rx_err_q, rx_err_d;

  logic            tx_busy_q, tx_busy_d, tx_line_q, tx_line_d, tx_done_q, tx_done_d;
  logic [8:0]      tx_sr_q, tx_sr_d;
  logic [CntW-1:0] tx_cnt_q, tx_cnt_d;
  logic [3:0]      tx_left_q, tx_left_d;

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      rx_s1_q    <= 1'b1;
      rx_s2_q    <= 1'b1;
      rx_s3_q    <= 1'b1;
      rx_state_q <= RxIdle;
      rx_cnt_q   <= '0;
      rx_bit_q   <= '0;
      rx_sr_q    <= '0;
      rx_valid_q <= 1'b0;
      rx_err_q   <= 1'b0;
      tx_busy_q  <= 1'b0;
      tx_line_q  <= 1'b1;
      tx_done_q  <= 1'b0;
      tx_sr_q    <= '1;
      tx_cnt_q   <= '0;
      tx_left_q  <= '0;
    end else begin
      rx_s1_q    <= uart_rx;
      rx_s2_q    <= rx_s1_q;
      rx_s3_q    <= rx_s2_q;
      rx_state_q <= rx_state_d;
      rx_cnt_q   <= rx_cnt_d;
      rx_bit_q   <= rx_bit_d;
      rx_sr_q    <= rx_sr_d;
      rx_valid_q <= rx_valid_d;
      rx_err_q   <= rx_err_d;
      tx_busy_q  <= tx_busy_d;
      tx_line_q  <= tx_line_d;
      tx_done_q  <= tx_done_d;
      tx_sr_q    <= tx_sr_d;
      tx_cnt_q   <= tx_cnt_d;
      tx_left_q  <= tx_left_d;
    end
  end

  // Receiver: the counter is loaded to land each sample in the middle of a bit.
  always_comb begin
    rx_state_d = rx_state_q;
    rx_cnt_d   = rx_cnt_q;
    rx_bit_d   = rx_bit_q;
    rx_sr_d    = rx_sr_q;
    rx_valid_d = 1'b0;
    rx_err_d   = 1'b0;
    if (rx_state_q == RxIdle) begin
      if (rx_s3_q && !rx_s2_q) begin
        rx_state_d = RxStart;
        rx_cnt_d   = HalfLast;
      end
    end else if (rx_cnt_q != '0) begin
      rx_cnt_d = rx_cnt_q - 1'b1;
    end else begin
      rx_cnt_d = BitLast;
      unique case (rx_state_q)
        RxStart: begin
          rx_state_d = rx_s2_q ? RxIdle : RxData;
          rx_bit_d   = '0;
        end
        RxData: begin
          rx_sr_d  = {rx_s2_q, rx_sr_q[7:1]};
          rx_bit_d = rx_bit_q + 1'b1;
          if (rx_bit_q == 3'd7) rx_state_d = RxStop;
        end
        RxStop: begin
          rx_state_d = RxIdle;
          rx_valid_d = rx_s2_q;
          rx_err_d   = !rx_s2_q;
        end
        default: rx_state_d = RxIdle;
      endcase
    end
  end

  // Transmitter: tx_sr holds data then stop; the start bit is driven on accept.
  always_comb begin
    tx_busy_d = tx_busy_q;
    tx_line_d = tx_line_q;
    tx_done_d = 1'b0;
    tx_sr_d   = tx_sr_q;
    tx_cnt_d  = tx_cnt_q;
    tx_left_d = tx_left_q;
    if (!tx_busy_q) begin
      if (tx_start_i) begin
        tx_busy_d = 1'b1;
        tx_line_d = 1'b0;
        tx_sr_d   = {1'b1, tx_data_i};
        tx_cnt_d  = BitLast;
        tx_left_d = 4'd9;
      end
    end else if (tx_cnt_q != '0) begin
      tx_cnt_d = tx_cnt_q - 1'b1;
    end else if (tx_left_q == '0) begin
      tx_busy_d = 1'b0;
      tx_done_d = 1'b1;
    end else begin
      tx_line_d = tx_sr_q[0];
      tx_sr_d   = {1'b1, tx_sr_q[8:1]};
      tx_left_d = tx_left_q - 1'b1;
      tx_cnt_d  = BitLast;
    end
  end

  assign uart_tx    = tx_line_q;
  assign tx_done_o  = tx_done_q;
  assign rx_valid_o = rx_valid_q;
  assign rx_err_o   = rx_err_q;
  assign rx_data_o  = rx_sr_q;

endmodule

// File: rtl/rv_uart_bus_master.sv
// UART command parser driving a data-memory initiator port; replies go back over UART.
module rv_uart_bus_master
  import rv_pkg::*;
#(
  parameter int unsigned CLK_FREQ     = 25_000_000,
  parameter int unsigned BAUD_RATE    = 9600,
  parameter int unsigned BYTE_TIMEOUT = 65535,
  parameter int unsigned BUS_TIMEOUT  = 1023
) (
  input  logic              clk_i,
  input  logic              arst_i,
  input  logic              uart_rx,
  output logic              uart_tx,
  output logic              data_req_o,
  output logic              data_we_o,
  output logic [XLEN/8-1:0] data_be_o,
  output logic [XLEN-1:0]   data_addr_o,
  output logic [XLEN-1:0]   data_wdata_o,
  input  logic              data_rvalid_i,
  input  logic [XLEN-1:0]   data_rdata_i,
  output logic              busy_o
);

  localparam int unsigned ByteTmrW = $clog2(BYTE_TIMEOUT) + 1;
  localparam int unsigned BusTmrW  = $clog2(BUS_TIMEOUT) + 1;

  dbg_state_t          state_q, state_d;
  logic                cmd_we_q, cmd_we_d;
  logic [XLEN-1:0]     addr_q, addr_d, wdata_q, wdata_d, resp_q, resp_d;
  logic [1:0]          byte_cnt_q, byte_cnt_d;
  logic [ByteTmrW-1:0] byte_tmr_q, byte_tmr_d;
  logic [BusTmrW-1:0]  bus_tmr_q, bus_tmr_d;
  logic [2:0]          resp_left_q, resp_left_d;
  logic                resp_kick_q, resp_kick_d;

  logic       rx_valid, rx_err, tx_start, tx_done, bus_act;
  logic [7:0] rx_data;

  rv_uart_phy #(
    .CLK_FREQ (CLK_FREQ),
    .BAUD_RATE(BAUD_RATE)
  ) u_phy (
    .clk_i     (clk_i),
    .arst_i    (arst_i),
    .uart_rx   (uart_rx),
    .uart_tx   (uart_tx),
    .rx_valid_o(rx_valid),
    .rx_err_o  (rx_err),
    .rx_data_o (rx_data),
    .tx_start_i(tx_start),
    .tx_data_i (resp_q[7:0]),
    .tx_done_o (tx_done)
  );

  always_ff @(posedge clk_i or posedge arst_i) begin
    if (arst_i) begin
      state_q     <= S_IDLE;
      cmd_we_q    <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
      resp_q      <= '0;
      byte_cnt_q  <= '0;
      byte_tmr_q  <= '0;
      bus_tmr_q   <= '0;
      resp_left_q <= '0;
      resp_kick_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      cmd_we_q    <= cmd_we_d;
      addr_q      <= addr_d;
      wdata_q     <= wdata_d;
      resp_q      <= resp_d;
      byte_cnt_q  <= byte_cnt_d;
      byte_tmr_q  <= byte_tmr_d;
      bus_tmr_q   <= bus_tmr_d;
      resp_left_q <= resp_left_d;
      resp_kick_q <= resp_kick_d;
    end
  end

  always_comb begin
    state_d     = state_q;
    cmd_we_d    = cmd_we_q;
    addr_d      = addr_q;
    wdata_d     = wdata_q;
    resp_d      = resp_q;
    byte_cnt_d  = byte_cnt_q;
    byte_tmr_d  = '0;
    bus_tmr_d   = bus_tmr_q;
    resp_left_d = resp_left_q;
    resp_kick_d = resp_kick_q;
    unique case (state_q)
      S_IDLE: begin
        if (rx_valid) begin
          if (rx_data == CMD_WRITE || rx_data == CMD_READ) begin
            cmd_we_d   = (rx_data == CMD_WRITE);
            byte_cnt_d = '0;
            state_d    = S_ADDR;
          end else begin
            resp_d      = XLEN'(RSP_ERR);
            resp_left_d = 3'd1;
            resp_kick_d = 1'b1;
            state_d     = S_RESP;
          end
        end
      end
      S_ADDR, S_DATA: begin
        byte_tmr_d = byte_tmr_q + 1'b1;
        if (rx_err) begin
          state_d = S_IDLE;
        end else if (rx_valid) begin
          byte_tmr_d = '0;
          byte_cnt_d = byte_cnt_q + 1'b1;
          if (state_q == S_ADDR) addr_d = {rx_data, addr_q[XLEN-1:8]};
          else                   wdata_d = {rx_data, wdata_q[XLEN-1:8]};
          if (byte_cnt_q == 2'd3) begin
            state_d = (state_q == S_ADDR && cmd_we_q) ? S_DATA : S_BUS_REQ;
          end
        end else if (byte_tmr_q == ByteTmrW'(BYTE_TIMEOUT - 1)) begin
          state_d = S_IDLE;
        end
      end
      S_BUS_REQ: begin
        bus_tmr_d = BusTmrW'(1);
        state_d   = S_BUS_WAIT;
      end
      S_BUS_WAIT: begin
        // bus_tmr_q counts clocks elapsed since the request edge.
        bus_tmr_d = bus_tmr_q + 1'b1;
        if (data_rvalid_i) begin
          resp_d      = cmd_we_q ? XLEN'(RSP_ACK) : data_rdata_i;
          resp_left_d = cmd_we_q ? 3'd1 : 3'd4;
          resp_kick_d = 1'b1;
          state_d     = S_RESP;
        end else if (bus_tmr_q == BusTmrW'(BUS_TIMEOUT - 1)) begin
          resp_d      = XLEN'(RSP_TMO);
          resp_left_d = 3'd1;
          resp_kick_d = 1'b1;
          state_d     = S_RESP;
        end
      end
      S_RESP: begin
        if (tx_start) begin
          resp_d      = resp_q >> 8;
          resp_left_d = resp_left_q - 1'b1;
          resp_kick_d = 1'b0;
        end else if (tx_done && resp_left_q == '0) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    bus_act      = (state_q == S_BUS_REQ) || (state_q == S_BUS_WAIT);
    busy_o       = (state_q != S_IDLE);
    data_req_o   = (state_q == S_BUS_REQ);
    data_we_o    = bus_act && cmd_we_q;
    data_be_o    = bus_act ? '1 : '0;
    data_addr_o  = bus_act ? addr_q : '0;
    data_wdata_o = bus_act ? wdata_q : '0;
    tx_start     = (state_q == S_RESP) && (resp_left_q != '0) && (resp_kick_q || tx_done);
  end

endmodule

// File: doc/rv_uart_bus_master.md
Name: rv_uart_bus_master

Overview:
- UART-to-bus bridge (debug/loader port): receives command frames on uart_rx and acts as initiator on a data memory interface.
- Targets are responders such as RAM or the UART peripheral. Results go back on uart_tx.
- Used to load programs and peek/poke memory while the core is held in reset.

Parameters:
- CLK_FREQ, 25_000_000, clk_i frequency in Hz.
- BAUD_RATE, 9600, UART bit rate; CLKS_PER_BIT = CLK_FREQ / BAUD_RATE (integer divide).
- BYTE_TIMEOUT, 65535, idle clocks between frame bytes before the parser resyncs to IDLE.
- BUS_TIMEOUT, 1023, clocks allowed from data_req_o to data_rvalid_i.

Ports:
- clk_i  in  1  clock.
- arst_i  in  1  asynchronous reset, active-high.
- uart_rx  in  1  serial input, 8N1, LSB first.
- uart_tx  out  1  serial output, 8N1, LSB first, idle high.
- data_req_o  out  1  request pulse.
- data_we_o  out  1  1 = write, 0 = read.
- data_be_o  out  XLEN/8  byte enables.
- data_addr_o  out  XLEN  address.
- data_wdata_o  out  XLEN  write data.
- data_rvalid_i  in  1  responder completion.
- data_rdata_i  in  XLEN  read data, valid with data_rvalid_i.
- busy_o  out  1  high whenever the FSM is not in S_IDLE.

Behaviour:
- Reset values: uart_tx=1; data_req_o=0; data_we_o=0; data_be_o=0; data_addr_o=0; data_wdata_o=0; busy_o=0; FSM in S_IDLE.
- RX path:
  - uart_rx passes through a 2-FF synchronizer (reset value 1).
  - A falling edge while the receiver is idle starts a byte.
  - Sampling points: CLKS_PER_BIT/2 after the edge (start bit), then every CLKS_PER_BIT.
  - Start sample = 1: false start, discard and return to idle.
  - Stop sample = 0: framing error; drop the byte and force the parser to S_IDLE.
  - A good byte raises a one-cycle rx_valid at the stop-bit sample.
- TX path:
  - Accepts a byte only when idle; sends start bit, 8 data bits, stop bit, each exactly CLKS_PER_BIT clocks.
  - tx_done pulses for one cycle after the stop bit.
- Frame format (multi-byte fields little-endian):
  - CMD_WRITE 0x57: ADDR[4], DATA[4].
  - CMD_READ 0x52: ADDR[4].
- Parser FSM, states S_IDLE, S_ADDR, S_DATA, S_BUS_REQ, S_BUS_WAIT, S_RESP:
  - S_IDLE, rx_valid with 0x57 or 0x52: latch command, go to S_ADDR. Any other byte: queue response 0x45 'E', go to S_RESP.
  - S_ADDR: shift in 4 bytes (byte0 → addr[7:0]). After byte 4, write goes to S_DATA, read goes to S_BUS_REQ.
  - S_DATA: 4 bytes into wdata, then go to S_BUS_REQ.
  - Inter-byte timer in S_ADDR/S_DATA: reloads on each rx_valid. Reaching BYTE_TIMEOUT returns to S_IDLE silently, with no bus access.
  - S_BUS_REQ: data_req_o=1 for exactly one cycle. addr/we/wdata/be (be = all ones) are driven stable from this cycle until data_rvalid_i is seen. Next state S_BUS_WAIT.
  - S_BUS_WAIT, data_rvalid_i=1:
    - write: queue 0x4B 'K'.
    - read: capture data_rdata_i and queue its 4 bytes LSB first.
    - Go to S_RESP.
  - S_BUS_WAIT, BUS_TIMEOUT clocks elapse first: queue 0x54 'T', go to S_RESP.
  - data_rvalid_i in any other state is ignored.
  - S_RESP: hand queued bytes to TX back-to-back, each on the tx_done of the previous one. After the last tx_done, return to S_IDLE.
- Bytes received outside S_IDLE/S_ADDR/S_DATA are discarded; no buffering.
- arst_i mid-frame or mid-transfer: everything returns to reset values immediately, and uart_tx goes high even mid-bit.
- Counters are sized $clog2(max)+1; no wrap-around is reachable in normal use.

Decomposition:
- rv_pkg gains:
  - CMD_WRITE=8'h57, CMD_READ=8'h52.
  - RSP_ACK=8'h4B, RSP_ERR=8'h45, RSP_TMO=8'h54.
  - Enum dbg_state_t with the states above.
- One sub-module, rv_uart_phy: synchronizer, RX and TX byte engines, baud counters, parameterised by CLK_FREQ and BAUD_RATE.
- Top level holds the parser FSM, address/data shift registers and timers.

Test Plan:
Bench uses CLK_FREQ=1_000_000, BAUD_RATE=100_000 (10 clocks/bit) and a RAM responder with 1-cycle rvalid.
- Write: send 57 10 00 00 00 EF BE AD DE → one data_req_o pulse with addr=0x00000010, we=1, be=4'hF, wdata=0xDEADBEEF; uart_tx returns 0x4B.
- Read: send 52 10 00 00 00 to the same RAM → req with we=0, addr=0x10; uart_tx returns EF BE AD DE, each frame exactly 100 clocks.
- Bad command: send 0x33 → no req; response 0x45; a following valid read succeeds.
- Stall/timeouts: responder never answers → 'T' exactly BUS_TIMEOUT clocks after req. Separately, send 52 10 then idle BYTE_TIMEOUT clocks → silent return to S_IDLE, no req.
- Framing: a byte with stop bit 0 mid-address → frame dropped, no req, busy_o falls.
- Reset: assert arst_i during the second response byte → uart_tx=1 and busy_o=0 immediately; a new write then completes normally.
